// File: rtl/gbox66_pkg.sv
// Shared 64b/66b gearbox definitions, used by both the TX gearbox and the RX seeker/gearbox path.
package gbox66_pkg;

  localparam int C_BLK_W       = 66;
  localparam int C_WORD_W      = 32;
  localparam int C_GBOX_PERIOD = 33;

  localparam logic [1:0] C_DATA_HEADER = 2'b01;
  localparam logic [1:0] C_CMD_HEADER  = 2'b10;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] payload;
  } blk66_t;

  // Only 01 and 10 are legal sync headers
  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return (hdr == 2'b00) || (hdr == 2'b11);
  endfunction

endpackage

// File: rtl/tx_gearbox66_if.sv
// Block handshake and serializer-side signals of the TX 66b->32b gearbox.
interface tx_gearbox66_if;
  import gbox66_pkg::*;

  logic [63:0] blk_data_i;
  logic [1:0]  blk_hdr_i;
  logic        blk_valid_i;
  logic        blk_ready_o;
  logic [31:0] tx_data_o;
  logic        tx_dv_o;
  logic [5:0]  gbox_cnt_o;
  logic        idle_ins_o;
  logic        hdr_err_o;

  modport master (
    output blk_data_i, blk_hdr_i, blk_valid_i,
    input  blk_ready_o, tx_data_o, tx_dv_o, gbox_cnt_o, idle_ins_o, hdr_err_o
  );

  modport slave (
    input  blk_data_i, blk_hdr_i, blk_valid_i,
    output blk_ready_o, tx_data_o, tx_dv_o, gbox_cnt_o, idle_ins_o, hdr_err_o
  );

endinterface

// File: rtl/tx_scrambler58.sv
// Self-synchronizing x^58 + x^39 + 1 payload scrambler, 64 bits per load, MSB first.
module tx_scrambler58
  import gbox66_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic [63:0] plain,
  output logic [63:0] scrambled
);

  logic [57:0] state_r;
  logic [57:0] state_next_s;

  // Bit-serial scramble of the whole payload; state_next_s is the state after the last bit
  always_comb begin
    logic [57:0] s;
    logic        b;
    s         = state_r;
    b         = 1'b0;
    scrambled = 64'd0;
    for (int i = 63; i >= 0; i--) begin
      b            = plain[i] ^ s[38] ^ s[57];
      scrambled[i] = b;
      s            = {s[56:0], b};
    end
    state_next_s = s;
  end

  // Scrambler state advances only when the gearbox consumes a block
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= '1;
    end else if (load) begin
      state_r <= state_next_s;
    end
  end

endmodule

// File: rtl/tx_gearbox66.sv
// TX 66b->32b gearbox with idle insertion. Optional payload scrambling under TX_SCRAMBLER_EN.
module tx_gearbox66
  import gbox66_pkg::*;
#(
  parameter logic [1:0]  IDLE_HEADER  = 2'b10,
  parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tx_gearbox66_if.slave  bus
);

  logic [95:0]  res_r;
  logic [6:0]   lvl_r;
  logic [5:0]   cnt_r;
  logic [31:0]  tx_data_r;
  logic         tx_dv_r;
  logic         idle_ins_r;
  logic         hdr_err_r;

  logic         load_s;
  blk66_t       raw_blk_s;
  logic [63:0]  payload_s;
  logic [161:0] comb_s;
  logic [6:0]   lvl_next_s;

  // Fewer than one word of residual bits means a block must be taken this cycle
  assign load_s = (lvl_r < 7'd32);

  // Upstream block when offered, otherwise an idle command block
  always_comb begin
    raw_blk_s = '0;
    if (bus.blk_valid_i) begin
      raw_blk_s.hdr     = bus.blk_hdr_i;
      raw_blk_s.payload = bus.blk_data_i;
    end else begin
      raw_blk_s.hdr     = IDLE_HEADER;
      raw_blk_s.payload = IDLE_PAYLOAD;
    end
  end

`ifdef TX_SCRAMBLER_EN
  tx_scrambler58 u_scrambler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load_s),
    .plain     (raw_blk_s.payload),
    .scrambled (payload_s)
  );
`else
  assign payload_s = raw_blk_s.payload;
`endif

  // Append the loaded block directly below the lvl valid residual bits
  always_comb begin
    comb_s = {res_r, 66'd0};
    if (load_s) begin
      comb_s     = comb_s | ({96'd0, raw_blk_s.hdr, payload_s} << (7'd96 - lvl_r));
      lvl_next_s = lvl_r + 7'd34;
    end else begin
      lvl_next_s = lvl_r - 7'd32;
    end
  end

  // Gearbox state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_r      <= 96'd0;
      lvl_r      <= 7'd0;
      cnt_r      <= 6'd0;
      tx_data_r  <= 32'd0;
      tx_dv_r    <= 1'b0;
      idle_ins_r <= 1'b0;
      hdr_err_r  <= 1'b0;
    end else begin
      res_r      <= comb_s[129:34];
      lvl_r      <= lvl_next_s;
      cnt_r      <= (cnt_r == 6'd32) ? 6'd0 : cnt_r + 6'd1;
      tx_data_r  <= comb_s[161:130];
      tx_dv_r    <= 1'b1;
      idle_ins_r <= load_s & ~bus.blk_valid_i;
      hdr_err_r  <= load_s & bus.blk_valid_i & hdr_invalid(bus.blk_hdr_i);
    end
  end

  assign bus.blk_ready_o = load_s;
  assign bus.tx_data_o   = tx_data_r;
  assign bus.tx_dv_o     = tx_dv_r;
  assign bus.gbox_cnt_o  = cnt_r;
  assign bus.idle_ins_o  = idle_ins_r;
  assign bus.hdr_err_o   = hdr_err_r;

endmodule

// File: tb/tb_tx_gearbox66.sv
// Bench for tx_gearbox66: bit-queue reference model of the serial stream (scrambled when TX_SCRAMBLER_EN).
module tb_tx_gearbox66;
  import gbox66_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  tx_gearbox66_if bus ();
  tx_gearbox66 dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  bit mq[$];
  bit sq[$];
  int mcnt;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int ready_cnt, idle_cnt;
  bit last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    sq.delete();
    for (int i = 0; i < 58; i++) sq.push_back(1'b1);
    mcnt = 0;
  endfunction

  // sq holds the last 58 scrambled bits, oldest first
  function automatic logic [63:0] model_scramble(input logic [63:0] d);
    logic [63:0] o;
    o = d;
`ifdef TX_SCRAMBLER_EN
    for (int i = 63; i >= 0; i--) begin
      o[i] = d[i] ^ sq[19] ^ sq[0];
      sq.push_back(o[i]);
      void'(sq.pop_front());
    end
`endif
    return o;
  endfunction

  task automatic cycle(input bit v, input logic [1:0] h, input logic [63:0] d);
    bit          rdy;
    logic [65:0] blk;
    logic [31:0] w;
    bus.blk_valid_i = v;
    bus.blk_hdr_i   = h;
    bus.blk_data_i  = d;
    rdy = (mq.size() < 32);
    chk("ready", {63'd0, bus.blk_ready_o}, {63'd0, rdy});
    chk("cnt0_iff_lvl0", {63'd0, bus.gbox_cnt_o == 6'd0}, {63'd0, mq.size() == 0});
    @(posedge clk_i);
    if (rdy) begin
      if (v) blk = {h, model_scramble(d)};
      else   blk = {2'b10, model_scramble(64'h7800_0000_0000_0000)};
      for (int i = 65; i >= 0; i--) mq.push_back(blk[i]);
      ready_cnt++;
      if (!v) idle_cnt++;
    end
    last_rdy = rdy;
    w = 32'd0;
    for (int i = 31; i >= 0; i--) w[i] = mq.pop_front();
    mcnt = (mcnt + 1) % 33;
    #1;
    chk("tx_data", {32'd0, bus.tx_data_o}, {32'd0, w});
    chk("tx_dv", {63'd0, bus.tx_dv_o}, 64'd1);
    chk("idle_ins", {63'd0, bus.idle_ins_o}, {63'd0, rdy && !v});
    chk("hdr_err", {63'd0, bus.hdr_err_o}, {63'd0, rdy && v && (h == 2'b00 || h == 2'b11)});
    chk("gbox_cnt", {58'd0, bus.gbox_cnt_o}, 64'(mcnt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, {32'd0, bus.tx_data_o}, 64'd0);
    chk({tag, "_tx_dv"}, {63'd0, bus.tx_dv_o}, 64'd0);
    chk({tag, "_cnt"}, {58'd0, bus.gbox_cnt_o}, 64'd0);
    chk({tag, "_idle"}, {63'd0, bus.idle_ins_o}, 64'd0);
    chk({tag, "_err"}, {63'd0, bus.hdr_err_o}, 64'd0);
    chk({tag, "_ready"}, {63'd0, bus.blk_ready_o}, 64'd1);
  endtask

  initial begin
    int k;
    int rc;
    bit sent;
    logic [1:0] h;
    bus.blk_valid_i = 1'b0;
    bus.blk_hdr_i   = 2'b00;
    bus.blk_data_i  = 64'd0;
    rst_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    #3 rst_i = 1'b0;

    // Idle-only stream for two full patterns
    idle_cnt = 0;
    repeat (66) cycle(1'b0, 2'b01, 64'd0);
    chk("idle_count_66", 64'(idle_cnt), 64'd32);

    // Continuous counter payloads: 16 loads per 33 cycles
    ready_cnt = 0;
    k = 0;
    repeat (33) begin
      cycle(1'b1, 2'b01, 64'(k));
      if (last_rdy) k++;
    end
    chk("ready_per_33", 64'(ready_cnt), 64'd16);

    // One block with each illegal header
    sent = 1'b0;
    repeat (6) begin
      h = sent ? 2'b11 : 2'b00;
      cycle(1'b1, h, {$urandom, $urandom});
      if (last_rdy) sent = 1'b1;
    end

    // Stalls on the 5th and 6th ready cycles
    rc = 0;
    idle_cnt = 0;
    repeat (33) begin
      cycle(!(rc == 4 || rc == 5), 2'b01, 64'(k));
      if (last_rdy) begin
        rc++;
        k++;
      end
    end
    chk("stall_idles", 64'(idle_cnt), 64'd2);

    // Random traffic, headers mostly legal
    repeat (200) begin
      h = ($urandom_range(0, 7) == 0) ? 2'($urandom) : (($urandom & 1) ? 2'b01 : 2'b10);
      cycle(1'($urandom), h, {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of a pattern
    for (int n = 0; n < 40 && mcnt != 17; n++) cycle(1'b1, 2'b01, {$urandom, $urandom});
    chk("reached_cnt17", {58'd0, bus.gbox_cnt_o}, 64'd17);
    #3 rst_i = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk_i);
    #4 rst_i = 1'b0;

    // All-zero data payloads after restart
    repeat (66) cycle(1'b1, 2'b01, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
